// File: rtl/retro_cache_line_controller_if.sv
// Bus bundle for the one-cycle cartridge cache sequencer: core port, storage
// BRAM port, backing-source port and flush handshake. Suffixes are from the
// controller's point of view.
interface retro_cache_line_controller_if #(
  parameter int AddressBusWidth = 16,
  parameter int CacheLineBits   = 7,
  parameter int CacheIndexBits  = 7
);
  logic                                    core_access_i;
  logic                                    core_write_i;
  logic [AddressBusWidth-1:0]              core_address_i;
  logic [7:0]                              core_din_i;
  logic [7:0]                              core_dout_o;
  logic                                    delay_o;

  logic                                    storage_access_o;
  logic                                    storage_write_o;
  logic [CacheIndexBits+CacheLineBits-1:0] storage_address_o;
  logic [7:0]                              storage_dout_o;
  logic [7:0]                              storage_din_i;

  logic                                    source_access_o;
  logic                                    source_write_o;
  logic [AddressBusWidth-1:0]              source_address_o;
  logic [7:0]                              source_dout_o;
  logic [7:0]                              source_din_i;
  logic                                    source_ready_i;

  logic                                    flush_request_i;
  logic                                    flush_busy_o;

  // Controller side
  modport slave (
    input  core_access_i, core_write_i, core_address_i, core_din_i,
    output core_dout_o, delay_o,
    output storage_access_o, storage_write_o, storage_address_o, storage_dout_o,
    input  storage_din_i,
    output source_access_o, source_write_o, source_address_o, source_dout_o,
    input  source_din_i, source_ready_i,
    input  flush_request_i,
    output flush_busy_o
  );

  // Core / memory environment side
  modport master (
    output core_access_i, core_write_i, core_address_i, core_din_i,
    input  core_dout_o, delay_o,
    input  storage_access_o, storage_write_o, storage_address_o, storage_dout_o,
    output storage_din_i,
    input  source_access_o, source_write_o, source_address_o, source_dout_o,
    output source_din_i, source_ready_i,
    output flush_request_i,
    input  flush_busy_o
  );
endinterface

// File: rtl/retro_cache_line_controller.sv
// Cartridge one-cycle cache sequencer: serves hits straight from the storage
// BRAM, stalls the core on a miss, writes back a dirty victim line, refills the
// aligned line from the source and runs whole-cache flushes of dirty lines.
module retro_cache_line_controller #(
  parameter int AddressBusWidth = 16,
  parameter int CacheLineBits   = 7,
  parameter int CacheIndexBits  = 7
) (
  input logic clk,
  input logic rst_n,
  retro_cache_line_controller_if.slave bus
);
  localparam int TagBits = AddressBusWidth - CacheIndexBits - CacheLineBits;
  localparam int Lines   = 1 << CacheIndexBits;

  typedef enum logic [2:0] {IDLE, WB_READ, WB_SEND, FILL, FLUSH_SCAN} state_e;

  state_e                    state_q;
  logic [TagBits-1:0]        tag_q [Lines];
  logic [Lines-1:0]          valid_q;
  logic [Lines-1:0]          dirty_q;
  logic [CacheLineBits-1:0]  count_q;
  logic [CacheIndexBits-1:0] line_idx_q;
  logic [CacheIndexBits-1:0] flush_idx_q;
  logic [TagBits-1:0]        victim_tag_q;
  logic [TagBits-1:0]        fill_tag_q;
  logic [7:0]                data_q;
  logic                      wb_first_q;   // first cycle of WB_SEND: BRAM data is live
  logic                      flush_pend_q;
  logic                      flush_wb_q;   // current writeback belongs to a flush

  logic [TagBits-1:0]        core_tag;
  logic [CacheIndexBits-1:0] core_idx;
  logic [CacheLineBits-1:0]  core_off;
  logic                      hit;
  logic                      last_byte;
  logic                      fill_done;

  assign core_tag  = bus.core_address_i[AddressBusWidth-1 -: TagBits];
  assign core_idx  = bus.core_address_i[CacheLineBits +: CacheIndexBits];
  assign core_off  = bus.core_address_i[CacheLineBits-1:0];
  assign hit       = valid_q[core_idx] && (tag_q[core_idx] == core_tag);
  assign last_byte = &count_q;
  assign fill_done = (state_q == FILL) && bus.source_ready_i && last_byte;

  // Tag store: committed when the last byte of a fill lands; Valid gates it
  always_ff @(posedge clk) begin
    if (fill_done) tag_q[line_idx_q] <= fill_tag_q;
  end

  // Main sequencer: miss handling, writeback/fill byte loop and flush scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      count_q      <= '0;
      line_idx_q   <= '0;
      flush_idx_q  <= '0;
      victim_tag_q <= '0;
      fill_tag_q   <= '0;
      data_q       <= '0;
      wb_first_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_wb_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.core_access_i) begin
            if (hit) begin
              if (bus.core_write_i) dirty_q[core_idx] <= 1'b1;
            end else begin
              line_idx_q   <= core_idx;
              fill_tag_q   <= core_tag;
              victim_tag_q <= tag_q[core_idx];
              count_q      <= '0;
              flush_wb_q   <= 1'b0;
              state_q      <= (valid_q[core_idx] && dirty_q[core_idx]) ? WB_READ : FILL;
            end
          end else if (flush_pend_q) begin
            flush_idx_q <= '0;
            state_q     <= FLUSH_SCAN;
          end
        end
        FLUSH_SCAN: begin
          if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
            // Revisit this index after the writeback; it will then be clean
            line_idx_q   <= flush_idx_q;
            victim_tag_q <= tag_q[flush_idx_q];
            count_q      <= '0;
            flush_wb_q   <= 1'b1;
            state_q      <= WB_READ;
          end else begin
            flush_idx_q <= flush_idx_q + CacheIndexBits'(1);
            if (&flush_idx_q) begin
              flush_pend_q <= 1'b0;
              state_q      <= IDLE;
            end
          end
        end
        WB_READ: begin
          wb_first_q <= 1'b1;
          state_q    <= WB_SEND;
        end
        WB_SEND: begin
          if (wb_first_q) begin
            data_q     <= bus.storage_din_i;
            wb_first_q <= 1'b0;
          end
          if (bus.source_ready_i) begin
            count_q <= count_q + CacheLineBits'(1);
            if (last_byte) begin
              dirty_q[line_idx_q] <= 1'b0;
              state_q             <= flush_wb_q ? FLUSH_SCAN : FILL;
            end else begin
              state_q <= WB_READ;
            end
          end
        end
        FILL: begin
          if (bus.source_ready_i) begin
            count_q <= count_q + CacheLineBits'(1);
            if (last_byte) begin
              valid_q[line_idx_q] <= 1'b1;
              dirty_q[line_idx_q] <= 1'b0;
              state_q             <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // Sampled last so a request during the final scan cycle is not lost
      if (bus.flush_request_i) flush_pend_q <= 1'b1;
    end
  end

  // Storage and source port drive, decoded from the current state
  always_comb begin
    bus.storage_access_o  = 1'b0;
    bus.storage_write_o   = 1'b0;
    bus.storage_address_o = '0;
    bus.storage_dout_o    = '0;
    bus.source_access_o   = 1'b0;
    bus.source_write_o    = 1'b0;
    bus.source_address_o  = '0;
    bus.source_dout_o     = '0;
    case (state_q)
      IDLE: begin
        if (bus.core_access_i && hit) begin
          bus.storage_access_o  = 1'b1;
          bus.storage_write_o   = bus.core_write_i;
          bus.storage_address_o = {core_idx, core_off};
          bus.storage_dout_o    = bus.core_din_i;
        end
      end
      WB_READ: begin
        bus.storage_access_o  = 1'b1;
        bus.storage_address_o = {line_idx_q, count_q};
      end
      WB_SEND: begin
        bus.source_access_o  = 1'b1;
        bus.source_write_o   = 1'b1;
        bus.source_address_o = {victim_tag_q, line_idx_q, count_q};
        // BRAM data is forwarded on the first cycle, then held from the latch
        bus.source_dout_o    = wb_first_q ? bus.storage_din_i : data_q;
      end
      FILL: begin
        bus.source_access_o  = 1'b1;
        bus.source_address_o = {fill_tag_q, line_idx_q, count_q};
        if (bus.source_ready_i) begin
          bus.storage_access_o  = 1'b1;
          bus.storage_write_o   = 1'b1;
          bus.storage_address_o = {line_idx_q, count_q};
          bus.storage_dout_o    = bus.source_din_i;
        end
      end
      default: ;
    endcase
  end

  // A pending (not yet started) flush yields to the core in IDLE, so it does
  // not stall an access there; a running flush stalls it via state != IDLE.
  assign bus.delay_o      = bus.core_access_i && ((state_q != IDLE) || !hit);
  assign bus.core_dout_o  = bus.storage_din_i;
  assign bus.flush_busy_o = flush_pend_q;
endmodule

// File: tb/tb_retro_cache_line_controller.sv
// Bench for retro_cache_line_controller: directed scenarios plus random
// accesses, checked against an architectural memory model of the cache.
module tb_retro_cache_line_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  retro_cache_line_controller_if bus ();
  retro_cache_line_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Environment memories
  logic [7:0]  bram    [16384];
  logic [7:0]  src_mem [65536];   // backing store as written by the DUT
  logic [7:0]  coh_mem [65536];   // architectural value the core must see

  // Cache-state model
  bit          ref_valid [128];
  bit          ref_dirty [128];
  logic [1:0]  ref_tag   [128];

  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [15:0] rd_addr_q [$];

  int          ready_mode = 0;    // 0: always ready, 1: alternate starting low, 2: random
  int          stab_errs  = 0;
  bit          prev_stall = 1'b0;
  bit          acc_prev   = 1'b0;
  bit          ready_prev = 1'b0;
  logic [15:0] prev_addr  = '0;
  bit          prev_wr    = 1'b0;
  logic [7:0]  prev_dout  = '0;
  logic [6:0]  idx_set [3] = '{7'd5, 7'd6, 7'd77};

  // Storage BRAM: registered read, output holds when not read
  always @(posedge clk) begin
    if (bus.storage_access_o) begin
      if (bus.storage_write_o) bram[bus.storage_address_o] <= bus.storage_dout_o;
      else                     bus.storage_din_i <= bram[bus.storage_address_o];
    end
  end

  // Backing source responder: decides ready mid-cycle, logs completed transfers
  always @(negedge clk) begin : responder
    bit r;
    if (rst_n && prev_stall) begin
      if (!bus.source_access_o || bus.source_address_o !== prev_addr ||
          bus.source_write_o !== prev_wr || (prev_wr && bus.source_dout_o !== prev_dout))
        stab_errs++;
    end
    if (ready_mode == 0)      r = 1'b1;
    else if (ready_mode == 1) r = acc_prev && !ready_prev;
    else                      r = ($urandom_range(0, 3) != 0);
    bus.source_ready_i = r;
    bus.source_din_i   = src_mem[bus.source_address_o];
    if (bus.source_access_o && r) begin
      if (bus.source_write_o) begin
        src_mem[bus.source_address_o] = bus.source_dout_o;
        wr_addr_q.push_back(bus.source_address_o);
        wr_data_q.push_back(bus.source_dout_o);
      end else begin
        rd_addr_q.push_back(bus.source_address_o);
      end
    end
    prev_stall = rst_n && bus.source_access_o && !r;
    prev_addr  = bus.source_address_o;
    prev_wr    = bus.source_write_o;
    prev_dout  = bus.source_dout_o;
    acc_prev   = bus.source_access_o;
    ready_prev = r;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.core_access_i   = 1'b0;
    bus.core_write_i    = 1'b0;
    bus.flush_request_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    for (int i = 0; i < 128; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
    // Unwritten-back data is lost: the core now sees the backing store
    for (int a = 0; a < 65536; a++) coh_mem[a] = src_mem[a];
  endtask

  // One core access, held until Delay drops, checked against the model
  task automatic core_op(input logic [15:0] a, input bit wr, input logic [7:0] d,
                         input bit with_flush);
    logic [6:0]  idx;
    logic [1:0]  tg;
    logic [15:0] ea;
    bit          hit, dw;
    int          exp_delay, n, errs;
    idx = a[13:7];
    tg  = a[15:14];
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    dw  = !hit && ref_valid[idx] && ref_dirty[idx];
    // Each source byte costs one cycle per ready-low cycle plus one;
    // writeback adds a BRAM read cycle per byte.
    if (hit)                  exp_delay = 0;
    else if (ready_mode == 0) exp_delay = 1 + 128 + (dw ? 256 : 0);
    else if (ready_mode == 1) exp_delay = 1 + 256 + (dw ? 384 : 0);
    else                      exp_delay = -1;
    clear_logs();
    @(negedge clk);
    bus.core_access_i  = 1'b1;
    bus.core_write_i   = wr;
    bus.core_address_i = a;
    bus.core_din_i     = d;
    if (with_flush) bus.flush_request_i = 1'b1;
    #2;
    n = 0;
    while (bus.delay_o && n < 4000) begin
      @(negedge clk);
      bus.flush_request_i = 1'b0;
      #2;
      n++;
    end
    if (exp_delay >= 0) check("delay_cycles", n, exp_delay);
    else                check("delay_bounded", n < 4000, 1);
    @(negedge clk);
    bus.flush_request_i = 1'b0;
    bus.core_access_i   = 1'b0;
    bus.core_write_i    = 1'b0;
    #2;
    if (!wr) check("read_data", bus.core_dout_o, coh_mem[a]);
    errs = 0;
    if (dw) begin
      for (int j = 0; j < 128; j++) begin
        ea = {ref_tag[idx], idx, 7'(j)};
        if (j >= wr_addr_q.size() || wr_addr_q[j] !== ea || wr_data_q[j] !== coh_mem[ea]) errs++;
      end
    end
    check("wb_count", wr_addr_q.size(), dw ? 128 : 0);
    check("wb_bytes", errs, 0);
    errs = 0;
    if (!hit) begin
      for (int j = 0; j < 128; j++) begin
        ea = {tg, idx, 7'(j)};
        if (j >= rd_addr_q.size() || rd_addr_q[j] !== ea) errs++;
      end
    end
    check("fill_count", rd_addr_q.size(), hit ? 0 : 128);
    check("fill_addrs", errs, 0);
    if (!hit) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      ref_dirty[idx] = 1'b0;
    end
    if (wr) begin
      ref_dirty[idx] = 1'b1;
      coh_mem[a]     = d;
    end
    $display("[TB] op %s addr=%04h data=%02h hit=%0d delay=%0d", wr ? "wr" : "rd", a,
             wr ? d : bus.core_dout_o, hit, n);
  endtask

  // Wait for a flush to finish; every valid dirty line written back in index order
  task automatic wait_flush_and_check();
    int          n, errs, k;
    logic [15:0] ea;
    n = 0;
    while (bus.flush_busy_o && n < 5000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("flush_done", n < 5000, 1);
    k = 0;
    errs = 0;
    for (int i = 0; i < 128; i++) begin
      if (ref_valid[i] && ref_dirty[i]) begin
        for (int j = 0; j < 128; j++) begin
          ea = {ref_tag[i], 7'(i), 7'(j)};
          if (k >= wr_addr_q.size() || wr_addr_q[k] !== ea || wr_data_q[k] !== coh_mem[ea]) errs++;
          k++;
        end
        ref_dirty[i] = 1'b0;
      end
    end
    check("flush_write_count", wr_addr_q.size(), k);
    check("flush_write_data", errs, 0);
    $display("[TB] flush done cycles=%0d writes=%0d", n, wr_addr_q.size());
  endtask

  initial begin
    int          n;
    logic [15:0] a;
    bus.core_access_i   = 1'b0;
    bus.core_write_i    = 1'b0;
    bus.core_address_i  = '0;
    bus.core_din_i      = '0;
    bus.flush_request_i = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      src_mem[i] = 8'(i);
      coh_mem[i] = 8'(i);
    end
    do_reset();

    // Reset values
    check("rst_delay", bus.delay_o, 0);
    check("rst_flush_busy", bus.flush_busy_o, 0);
    check("rst_storage_access", bus.storage_access_o, 0);
    check("rst_storage_write", bus.storage_write_o, 0);
    check("rst_source_access", bus.source_access_o, 0);
    check("rst_source_write", bus.source_write_o, 0);
    check("rst_source_address", bus.source_address_o, 0);
    check("rst_storage_address", bus.storage_address_o, 0);

    // Clean miss then replay: 129 cycles, fill 0x1200..0x127F, data 0x34
    core_op(16'h1234, 1'b0, 8'h00, 1'b0);
    check("first_read_value", bus.core_dout_o, 8'h34);
    // Write hit, then conflicting tag forces a dirty writeback
    core_op(16'h1234, 1'b1, 8'hA5, 1'b0);
    core_op(16'h5234, 1'b0, 8'h00, 1'b0);
    check("wb_byte_a5", src_mem[16'h1234], 8'hA5);

    // Alternating SourceReady during a clean fill: 257 cycles, stable while stalled
    ready_mode = 1;
    core_op(16'h0085, 1'b0, 8'h00, 1'b0);
    ready_mode = 0;

    // Reset in the middle of a fill at Count=40
    clear_logs();
    @(negedge clk);
    bus.core_access_i  = 1'b1;
    bus.core_write_i   = 1'b0;
    bus.core_address_i = 16'h2A10;
    #2;
    n = 0;
    while (rd_addr_q.size() < 41 && n < 1000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("fill_reached_40", rd_addr_q.size(), 41);
    rst_n = 1'b0;
    #1;
    check("midfill_rst_source_access", bus.source_access_o, 0);
    do_reset();
    core_op(16'h2A10, 1'b0, 8'h00, 1'b0);

    // Flush of dirty lines at indices 3 and 100
    do_reset();
    core_op(16'h0185, 1'b1, 8'h3C, 1'b0);
    core_op(16'h3210, 1'b1, 8'h77, 1'b0);
    clear_logs();
    @(negedge clk);
    bus.flush_request_i = 1'b1;
    @(negedge clk);
    bus.flush_request_i = 1'b0;
    #2;
    check("flush_busy_set", bus.flush_busy_o, 1);
    wait_flush_and_check();
    check("flush_writes_256", wr_addr_q.size(), 256);
    check("flush_byte_idx3", src_mem[16'h0185], 8'h3C);
    core_op(16'h0185, 1'b0, 8'h00, 1'b0);
    core_op(16'h3210, 1'b0, 8'h00, 1'b0);
    core_op(16'h4180, 1'b0, 8'h00, 1'b0);

    // Flush request coincident with a miss: miss first, then the flush
    core_op(16'h3220, 1'b1, 8'h11, 1'b0);
    core_op(16'h0400, 1'b0, 8'h00, 1'b1);
    check("flush_pending_after_miss", bus.flush_busy_o, 1);
    clear_logs();
    wait_flush_and_check();
    check("flush_writes_128", wr_addr_q.size(), 128);

    // Random traffic over a few conflicting lines
    for (int t = 0; t < 40; t++) begin
      ready_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      a = {2'($urandom_range(0, 3)), idx_set[$urandom_range(0, 2)], 7'($urandom_range(0, 127))};
      core_op(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end
    ready_mode = 0;

    check("source_stability", stab_errs, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
